// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/sequencing controller: load-use bubble, taken-branch flush, mul/div EX occupancy.
// Optional stall-cycle performance counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CW         = $clog2(MD_LATENCY + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_RSAddress,
    input  logic [4:0]  IF_ID_RTAddress,
    input  logic        IF_ID_UsesRT,
    input  logic [4:0]  ID_EX_RTAddress,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_MulDiv,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        md_start,
    output logic        md_result_sel,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_use;

    // Address 0 is hard-wired zero, so a load targeting it never creates a real dependency.
    assign load_use = ID_EX_MemRead && (ID_EX_RTAddress != 5'd0) &&
                      ((ID_EX_RTAddress == IF_ID_RSAddress) ||
                       (IF_ID_UsesRT && (ID_EX_RTAddress == IF_ID_RTAddress)));

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Flush  = 1'b0;
        md_start      = 1'b0;
        md_result_sel = 1'b0;
        md_busy       = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (ID_EX_MulDiv) begin
                    md_start     = 1'b1;
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    state_d      = MD_RUN;
                    cnt_d        = CW'(MD_LATENCY - 1);
                end else if (BranchTaken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            MD_RUN: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Flush = 1'b1;
                md_busy      = 1'b1;
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            MD_DONE: begin
                // Result cycle: pipeline advances, so a held MulDiv is the finished op, not a new one.
                md_result_sel = 1'b1;
                md_busy       = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!PCWrite && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: IDLE vector table plus mul/div, back-to-back and reset sequences.
// Works with or without HAZARD_STALL_COUNTER_EN; the stall_cycles model follows the same macro.
module tb_hazard_stall_ctrl;

    localparam int MD_LATENCY = 8;
`ifdef HAZARD_STALL_COUNTER_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic       memread;
        logic       muldiv;
        logic       branch;
        logic       rst;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    // {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, md_start, md_result_sel, md_busy}
    localparam logic [8:0] O_DEF   = 9'b111_000_000;
    localparam logic [8:0] O_LU    = 9'b001_010_000;
    localparam logic [8:0] O_BR    = 9'b111_110_000;
    localparam logic [8:0] O_START = 9'b000_001_100;
    localparam logic [8:0] O_RUN   = 9'b000_001_001;
    localparam logic [8:0] O_DONE  = 9'b111_000_011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_RSAddress, IF_ID_RTAddress, ID_EX_RTAddress;
    logic        IF_ID_UsesRT, ID_EX_MemRead, ID_EX_MulDiv, BranchTaken;
    logic        PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush;
    logic        md_start, md_result_sel, md_busy;
    logic [31:0] stall_cycles;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_stall = 32'd0;
    vec_t        tbl[10];

    hazard_stall_ctrl #(.MD_LATENCY(MD_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_RSAddress(IF_ID_RSAddress), .IF_ID_RTAddress(IF_ID_RTAddress),
        .IF_ID_UsesRT(IF_ID_UsesRT), .ID_EX_RTAddress(ID_EX_RTAddress),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MulDiv(ID_EX_MulDiv), .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
        .md_start(md_start), .md_result_sel(md_result_sel), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic [4:0] ex_rt, input logic memread, input logic muldiv,
                               input logic branch, input logic r);
        in_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_rt = ex_rt;
        v.memread = memread; v.muldiv = muldiv; v.branch = branch; v.rst = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        IF_ID_RSAddress = v.rs;
        IF_ID_RTAddress = v.rt;
        IF_ID_UsesRT    = v.uses_rt;
        ID_EX_RTAddress = v.ex_rt;
        ID_EX_MemRead   = v.memread;
        ID_EX_MulDiv    = v.muldiv;
        BranchTaken     = v.branch;
        rst             = v.rst;
    endtask

    // Apply one cycle of inputs, compare outputs mid-cycle, then clock and advance the stall model.
    task automatic step(input string name, input in_t v, input logic [8:0] exp);
        drive(v);
        #1;
        check({name, ".out"}, {23'd0, PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
                               EX_MEM_Flush, md_start, md_result_sel, md_busy}, {23'd0, exp});
        check({name, ".stall"}, stall_cycles, exp_stall);
        @(posedge clk);
        if (v.rst) exp_stall = 32'd0;
        else if (STALL_EN && !exp[8] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        #1;
    endtask

    initial begin
        in_t idle_in, md_in, rst_in;
        idle_in = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        md_in   = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_in  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        tbl[0] = '{mk(5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0), O_DEF};
        tbl[1] = '{mk(5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0), O_LU};
        tbl[2] = '{mk(5'd5,  5'd0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0), O_DEF};
        tbl[3] = '{mk(5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0), O_DEF};
        tbl[4] = '{mk(5'd3,  5'd5, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0), O_DEF};
        tbl[5] = '{mk(5'd3,  5'd5, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0), O_LU};
        tbl[6] = '{mk(5'd4,  5'd6, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0), O_DEF};
        tbl[7] = '{mk(5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0), O_BR};
        tbl[8] = '{mk(5'd1,  5'd2, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b0), O_BR};
        tbl[9] = '{mk(5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0), O_LU};

        drive(rst_in);
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", idle_in, O_DEF);

        for (int i = 0; i < 10; i++) step($sformatf("tbl%0d", i), tbl[i].in, tbl[i].exp);

        // One load-use plus one mul/div from a clean counter: 1 + (MD_LATENCY+1) stalled cycles.
        step("rst_clear", rst_in, O_DEF);
        step("lu", mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), O_LU);
        step("lu_bubble", mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), O_DEF);
        step("md_start", md_in, O_START);
        for (int i = 0; i < MD_LATENCY; i++) step($sformatf("md_run%0d", i), md_in, O_RUN);
        step("md_done", md_in, O_DONE);
        step("md_idle", idle_in, O_DEF);
        check("stall_total", stall_cycles, STALL_EN ? 32'd10 : 32'd0);

        // Back-to-back op with MulDiv, branch and load-use all raised: MulDiv must win.
        step("b2b_start1", md_in, O_START);
        for (int i = 0; i < MD_LATENCY; i++) step($sformatf("b2b_run%0d", i), md_in, O_RUN);
        step("b2b_done1", md_in, O_DONE);
        step("b2b_prio", mk(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0), O_START);

        // Counter starts at MD_LATENCY-1 = 7; four run cycles bring it to 3, then reset.
        for (int i = 0; i < 4; i++) step($sformatf("rst_run%0d", i), md_in, O_RUN);
        step("rst_in_run", mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), O_RUN);
        step("after_rst", idle_in, O_DEF);
        check("after_rst_stall", stall_cycles, 32'd0);
        step("after_rst2", idle_in, O_DEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU. It sits alongside the forwarding unit.
- Handles the hazards forwarding cannot resolve:
  - load-use stall (one bubble);
  - taken-branch flush;
  - multi-cycle mul/div occupancy of EX, sequenced by an FSM and latency counter.
- Drives PC/IF_ID/ID_EX write enables, flushes, and the mul/div unit start/result-select.

Parameters:
- MD_LATENCY, 8: mul/div busy cycles after start; legal range 1..255.
- CW, $clog2(MD_LATENCY+1): latency counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- IF_ID_RSAddress  input  5  rs of instruction in ID
- IF_ID_RTAddress  input  5  rt of instruction in ID
- IF_ID_UsesRT  input  1  ID instruction reads rt as a source
- ID_EX_RTAddress  input  5  load destination in EX
- ID_EX_MemRead  input  1  EX instruction is a load
- ID_EX_MulDiv  input  1  EX instruction is mul/div
- BranchTaken  input  1  branch resolved taken in EX
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF_ID register enable
- ID_EX_Write  output  1  ID_EX register enable
- IF_ID_Flush  output  1  zero IF_ID on next edge
- ID_EX_Flush  output  1  insert bubble into ID_EX
- EX_MEM_Flush  output  1  insert bubble into EX_MEM
- md_start  output  1  one-cycle start pulse to mul/div unit
- md_result_sel  output  1  EX result mux selects mul/div output
- md_busy  output  1  FSM not IDLE
- stall_cycles  output  32  performance counter (see Optional Feature)

Behaviour:
- All outputs are combinational from FSM state + inputs. Only state, counter, and stall_cycles are registered.
- Defaults: PCWrite=IF_ID_Write=ID_EX_Write=1; all flushes, md_start, md_result_sel = 0.
- FSM states: IDLE, MD_RUN, MD_DONE. Reset → IDLE, counter=0, stall_cycles=0.
- IDLE:
  - ID_EX_MulDiv=1:
    - md_start=1, PCWrite=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1.
    - Next state MD_RUN; counter loads MD_LATENCY-1.
  - else BranchTaken=1:
    - IF_ID_Flush=1, ID_EX_Flush=1. No stall.
  - else load-use hazard (ID_EX_MemRead=1, ID_EX_RTAddress≠0, and ID_EX_RTAddress==IF_ID_RSAddress or (IF_ID_UsesRT and ID_EX_RTAddress==IF_ID_RTAddress)):
    - PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
    - Exactly one bubble: the bubble clears MemRead next cycle.
- MD_RUN:
  - Full stall: PCWrite=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1.
  - Counter decrements each cycle. At counter==0 the next state is MD_DONE.
  - Stays in MD_RUN for exactly MD_LATENCY cycles.
- MD_DONE:
  - Single cycle: md_result_sel=1, no stall, no flush; EX_MEM captures the result.
  - ID_EX_MulDiv is ignored in this state. Next state IDLE.
- Total freeze per mul/div = MD_LATENCY+1 cycles (start cycle + MD_RUN).
- Back-to-back mul/div: the second one is seen in IDLE the cycle after MD_DONE and restarts normally.
- Priority in IDLE: MulDiv > BranchTaken > load-use.
  - MulDiv and MemRead/BranchTaken describe the same EX instruction and are mutually exclusive in legal streams.
  - If asserted together anyway, MulDiv wins.
- md_busy=1 in MD_RUN and MD_DONE.
- rst asserted mid-operation (any state): next edge forces IDLE, counter=0, stall_cycles=0.
  - Outputs reflect IDLE from the cycle after reset.
  - While rst=1, outputs still follow the current-state equations.
- Register address 0 never triggers a load-use stall.

Optional Feature:
- Macro: HAZARD_STALL_COUNTER_EN.
- Defined:
  - stall_cycles increments on every cycle with PCWrite=0.
  - Saturates at 32'hFFFF_FFFF; no wrap.
  - Cleared only by rst.
- Undefined:
  - stall_cycles tied to 32'd0 and no counter register is built.
  - Port list unchanged.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RTAddress=5, IF_ID_RSAddress=5 → one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead=0) all defaults.
- Load-use suppressed: same as load-use but RT=0, or match on rt with IF_ID_UsesRT=0 → no stall, all defaults.
- Mul/div, MD_LATENCY=8:
  - ID_EX_MulDiv held 1 → md_start pulses 1 cycle; PCWrite=0 for exactly 9 cycles.
  - md_result_sel=1 on the 10th cycle; then IDLE with md_busy=0.
- Branch vs load-use: BranchTaken=1 together with a load-use match → IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1.
- Reset mid MD_RUN: rst asserted at counter=3 → next cycle IDLE, md_busy=0, PCWrite=1, stall_cycles=0.
- HAZARD_STALL_COUNTER_EN: one load-use stall plus one MD_LATENCY=8 op → stall_cycles=10. Build without the macro → stall_cycles=0 throughout.
